// File: rtl/fill_pkg.sv
// fill_pkg: constants and types shared by the BRAM fill engine and fill_check.
//   BURST_SIZE     : bytes per AXI INCR burst
//   AXI_BURST_INCR : ARBURST/AWBURST encoding for INCR
//   RESP_OKAY      : AXI OKAY response code
//   beats_of(dw)   : beats per burst at data width dw
//   lanes_of(dw)   : 32-bit words per beat at data width dw
//   ar_state_t / r_state_t / fsm_state_t : checker state encodings (debug view)
package fill_pkg;

  localparam int         BURST_SIZE     = 256;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_REQ  = 1'b1
  } ar_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } r_state_t;

  typedef struct packed {
    ar_state_t ar;
    r_state_t  r;
  } fsm_state_t;

  function automatic int beats_of(input int dw);
    return BURST_SIZE / (dw / 8);
  endfunction

  function automatic int lanes_of(input int dw);
    return dw / 32;
  endfunction

endpackage

// File: rtl/pattern_cmp.sv
// pattern_cmp: combinational check of one data beat against the fill pattern.
//   data     : DW-bit beat, lane i in data[32*i +: 32]
//   base     : expected value of lane 0
//   mismatch : high when any lane i differs from base+i (32-bit wrap)
module pattern_cmp
  import fill_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic [DW-1:0] data,
  input  logic [31:0]   base,
  output logic          mismatch
);

  localparam int LANES = lanes_of(DW);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (data[i*32 +: 32] != base + 32'(i)) mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/fill_check.sv
// fill_check: AXI4 read master that reads the whole BRAM back after a fill and
// checks every 32-bit word against the pattern "word at byte A holds A/4".
//   clk, resetn        : clock, asynchronous active-low reset
//   start              : pulse to begin a run (ignored while busy)
//   busy               : run in progress; also drives RREADY
//   done / pass        : run finished / finished with no failing beats
//   error_count        : failing beats (saturating)
//   first_error_addr   : byte address of first failing beat, 0 if none
//   M_AXI_AR*          : read address channel, fixed-size INCR bursts
//   M_AXI_R*           : read data channel (RID ignored)
//   dbg_state          : current state of both FSMs
//
// Handshakes: a transfer happens on a rising clk edge where VALID and READY are
// both high. ARVALID/ARADDR are held stable until that edge; RREADY is held
// high for the whole run so every RVALID beat is taken in the cycle it shows.
//
// Address issue (AR FSM) and data checking (R FSM) are independent: all bursts
// may be outstanding at once and the R side simply counts beats in order.
// AW must not exceed 32.
module fill_check
  import fill_pkg::*;
#(
  parameter int          IW        = 2,
  parameter int          AW        = 20,
  parameter int          DW        = 512,
  parameter logic [31:0] BRAM_SIZE = 32'h10_0000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [31:0]   error_count,
  output logic [AW-1:0] first_error_addr,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  output logic [7:0]    M_AXI_ARLEN,
  output logic [2:0]    M_AXI_ARSIZE,
  output logic [1:0]    M_AXI_ARBURST,
  output logic [IW-1:0] M_AXI_ARID,
  output logic          M_AXI_ARLOCK,
  output logic [3:0]    M_AXI_ARCACHE,
  output logic [3:0]    M_AXI_ARQOS,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic          M_AXI_ARREADY,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic [IW-1:0] M_AXI_RID,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RLAST,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY,
  output fsm_state_t    dbg_state
);

  localparam logic [31:0] TOTAL_BURSTS = BRAM_SIZE / BURST_SIZE;
  localparam int          BEATS        = beats_of(DW);
  localparam int          LANES        = lanes_of(DW);

  ar_state_t   ar_state;
  r_state_t    r_state;
  logic [31:0] ar_count;
  logic [31:0] r_count;
  logic [7:0]  beat;
  logic [31:0] expected;
  logic [31:0] err_next;
  logic        mismatch;
  logic        accept;
  logic        beat_fire;
  logic        last_in_burst;
  logic        final_beat;
  logic        beat_fail;
  logic [AW-1:0] beat_addr;
  logic        rid_unused;

  assign M_AXI_ARLEN   = 8'(BEATS - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_RREADY  = busy;
  assign rid_unused    = ^M_AXI_RID;

  assign dbg_state = '{ar: ar_state, r: r_state};

  // busy is low whenever the R FSM is idle, so done-high also accepts start.
  assign accept        = start && !busy;
  assign beat_fire     = M_AXI_RVALID && busy;
  assign last_in_burst = (beat == 8'(BEATS - 1));
  assign final_beat    = last_in_burst && (r_count == TOTAL_BURSTS);

  pattern_cmp #(.DW(DW)) u_cmp (
    .data     (M_AXI_RDATA),
    .base     (expected),
    .mismatch (mismatch)
  );

  // RLAST must appear on exactly the last beat of each burst.
  assign beat_fail = mismatch || (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != last_in_burst);

  // expected counts words from address 0, so the beat address is expected*4.
  assign beat_addr = AW'({expected[29:0], 2'b00});

  always_comb begin
    err_next = error_count;
    if (beat_fail && (error_count != 32'hFFFF_FFFF)) err_next = error_count + 32'd1;
  end

  // Address issue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state      <= AR_IDLE;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      ar_count      <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept) begin
            ar_state      <= AR_REQ;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= '0;
            ar_count      <= 32'd1;
          end
        end
        AR_REQ: begin
          if (M_AXI_ARREADY) begin
            if (ar_count == TOTAL_BURSTS) begin
              ar_state      <= AR_IDLE;
              M_AXI_ARVALID <= 1'b0;
            end else begin
              M_AXI_ARADDR <= M_AXI_ARADDR + AW'(BURST_SIZE);
              ar_count     <= ar_count + 32'd1;
            end
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // Data check
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= R_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
      expected         <= '0;
      beat             <= '0;
      r_count          <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (accept) begin
            r_state          <= R_RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            error_count      <= '0;
            first_error_addr <= '0;
            expected         <= '0;
            beat             <= '0;
            r_count          <= 32'd1;
          end
        end
        R_RUN: begin
          if (beat_fire) begin
            expected <= expected + 32'(LANES);
            if (beat_fail) begin
              error_count <= err_next;
              if (error_count == 32'd0) first_error_addr <= beat_addr;
            end
            if (final_beat) begin
              r_state <= R_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              // Uses err_next so a failure on the final beat is already seen.
              pass    <= (err_next == 32'd0);
            end else if (last_in_burst) begin
              beat    <= '0;
              r_count <= r_count + 32'd1;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_check.sv
module tb_fill_check;
  import fill_pkg::*;

  localparam int          IW        = 2;
  localparam int          AW        = 20;
  localparam int          DW        = 512;
  localparam logic [31:0] BRAM_SIZE = 32'h400;
  localparam int          WORDS     = 256;
  localparam int          BEATS     = 4;
  localparam int          LANES     = 16;
  localparam int          NBURST    = 4;

  // clock / reset
  logic clk;
  logic resetn;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          start;
  logic          busy, done, pass;
  logic [31:0]   error_count;
  logic [AW-1:0] first_error_addr;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          arlock;
  logic [3:0]    arcache, arqos;
  logic [2:0]    arprot;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  fsm_state_t    dbg_state;

  fill_check #(.IW(IW), .AW(AW), .DW(DW), .BRAM_SIZE(BRAM_SIZE)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_error_addr (first_error_addr),
    .M_AXI_ARADDR     (araddr),
    .M_AXI_ARVALID    (arvalid),
    .M_AXI_ARLEN      (arlen),
    .M_AXI_ARSIZE     (arsize),
    .M_AXI_ARBURST    (arburst),
    .M_AXI_ARID       (arid),
    .M_AXI_ARLOCK     (arlock),
    .M_AXI_ARCACHE    (arcache),
    .M_AXI_ARQOS      (arqos),
    .M_AXI_ARPROT     (arprot),
    .M_AXI_ARREADY    (arready),
    .M_AXI_RDATA      (rdata),
    .M_AXI_RID        (rid),
    .M_AXI_RRESP      (rresp),
    .M_AXI_RLAST      (rlast),
    .M_AXI_RVALID     (rvalid),
    .M_AXI_RREADY     (rready),
    .dbg_state        (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave model state
  logic [31:0]   mem [WORDS];
  logic [AW-1:0] ar_q[$];
  bit            stall_mode = 0;
  int            rresp_idx  = -1;
  int            ar_hs      = 0;
  int            beats_done = 0;
  bit            cur_active = 0;
  logic [AW-1:0] cur_addr;
  int            cur_beat;
  bit            consumed = 0;
  bit            arvalid_prev = 0, arready_prev = 0;
  logic [AW-1:0] araddr_prev;

  // Slave: all decisions at negedge, for the handshake at the next posedge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ar_q.delete();
        cur_active = 0; consumed = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        arvalid_prev = 0; arready_prev = 0;
      end else begin
        // R channel
        if (consumed) begin
          beats_done++;
          cur_beat++;
          if (cur_beat == BEATS) cur_active = 0;
        end
        if (!cur_active && ar_q.size() > 0) begin
          cur_addr   = ar_q.pop_front();
          cur_beat   = 0;
          cur_active = 1;
        end
        if (rvalid && !consumed) begin
          rvalid = 1'b1;  // hold the beat until taken
        end else if (cur_active && (!stall_mode || $urandom_range(0, 1) == 1)) begin
          for (int i = 0; i < LANES; i++)
            rdata[i*32 +: 32] = mem[int'(cur_addr) / 4 + cur_beat * LANES + i];
          rresp  = ((int'(cur_addr) / 64 + cur_beat) == rresp_idx) ? 2'b10 : 2'b00;
          rlast  = (cur_beat == BEATS - 1);
          rvalid = 1'b1;
        end else begin
          rvalid = 1'b0;
        end
        consumed = rvalid && rready;
        // AR channel
        if (arvalid_prev && !arready_prev && arvalid)
          check_eq("araddr_hold", araddr, araddr_prev);
        arready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (arvalid && arready) begin
          ar_q.push_back(araddr);
          ar_hs++;
          check_eq("araddr", araddr, (exp_q.size() > 0) ? exp_q.pop_front() : '1);
        end
        arvalid_prev = arvalid; arready_prev = arready; araddr_prev = araddr;
      end
    end
  end

  // driver tasks
  task automatic fill_mem();
    for (int n = 0; n < WORDS; n++) mem[n] = 32'(n);
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int b = 0; b < NBURST; b++) exp_q.push_back(AW'(b * 256));
    ar_hs = 0;
    beats_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    check_eq({tag, "_done"}, done, 1);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] exp_err,
                               input logic [AW-1:0] exp_first, input logic exp_pass);
    load_exp();
    pulse_start();
    check_eq({tag, "_busy_start"}, busy, 1);
    check_eq({tag, "_done_clr"}, done, 0);
    check_eq({tag, "_err_clr"}, error_count, 0);
    check_eq({tag, "_first_clr"}, first_error_addr, 0);
    wait_done(tag);
    check_eq({tag, "_pass"}, pass, exp_pass);
    check_eq({tag, "_err"}, error_count, exp_err);
    check_eq({tag, "_first"}, first_error_addr, exp_first);
    check_eq({tag, "_beats"}, beats_done, NBURST * BEATS);
    check_eq({tag, "_ar_hs"}, ar_hs, NBURST);
    check_eq({tag, "_exp_q_empty"}, exp_q.size(), 0);
    check_eq({tag, "_busy_end"}, busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_done_hold"}, done, 1);
    check_eq({tag, "_err_hold"}, error_count, exp_err);
    check_eq({tag, "_dbg_idle"}, dbg_state, 0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    fill_mem();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", error_count, 0);
    check_eq("rst_first", first_error_addr, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_araddr", araddr, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_dbg", dbg_state, 0);
    check_eq("arlen", arlen, 3);
    check_eq("arsize", arsize, 6);
    check_eq("arburst", arburst, 1);
    check_eq("ar_misc", {arid, arlock, arcache, arqos, arprot}, 0);
    @(negedge clk); #2;
    resetn = 1'b1;

    // clean run
    run_and_check("clean", 0, 0, 1);

    // corrupted word at byte 0x1C4
    mem[32'h1C4 / 4] = 32'hDEAD_BEEF;
    run_and_check("data_err", 1, 20'h1C0, 0);
    fill_mem();

    // bad response on beat 9
    rresp_idx = 9;
    run_and_check("rresp9", 1, 20'h240, 0);

    // failure on the final beat must already be reflected when done rises
    rresp_idx = 15;
    run_and_check("rresp_last", 1, 20'h3C0, 0);
    rresp_idx = -1;

    // two failing beats: count both, keep first address
    mem[32'h044 / 4] = 32'h0;
    mem[32'h388 / 4] = 32'h1;
    run_and_check("two_err", 2, 20'h040, 0);
    fill_mem();

    // random AR stalls and R gaps
    stall_mode = 1;
    run_and_check("stall", 0, 0, 1);
    stall_mode = 0;

    // start while busy is ignored
    load_exp();
    pulse_start();
    repeat (2) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (4) @(negedge clk);
    #1;
    check_eq("busy_start_ar_hs", ar_hs, NBURST);
    check_eq("busy_start_beats", beats_done, NBURST * BEATS);
    check_eq("busy_start_pass", pass, 1);

    // reset mid-run
    mem[1] = 32'hFFFF_0000;
    load_exp();
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      if (beats_done >= 6) break;
      @(negedge clk); #1;
    end
    check_eq("mid_err_before", error_count, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mid_busy", busy, 0);
    check_eq("mid_done", done, 0);
    check_eq("mid_err", error_count, 0);
    check_eq("mid_first", first_error_addr, 0);
    check_eq("mid_araddr", araddr, 0);
    check_eq("mid_rready", rready, 0);
    check_eq("mid_dbg", dbg_state, 0);
    repeat (2) @(negedge clk);
    #2;
    exp_q.delete();
    resetn = 1'b1;
    fill_mem();
    repeat (2) @(negedge clk);
    #1;
    check_eq("mid_no_done", done, 0);
    run_and_check("after_rst", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fill_check.md
Name: fill_check

Overview:
- AXI4 read master that sits directly downstream of the BRAM fill engine.
- After the fill completes, it reads back the whole BRAM in 256-byte INCR bursts.
- It checks every 32-bit word against the fill pattern (word at byte address A holds A/4) and reports pass/fail, error count and first failing beat address.

Parameters:
IW, 2, AXI ID width
AW, 20, AXI address width
DW, 512, data width; multiple of 32, DW/8 divides 256
BRAM_SIZE, 32'h10_0000, bytes checked; multiple of 256

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse begins a check run; ignored while busy
busy  out  1  high from cycle after accepted start until done asserts
done  out  1  high from cycle after final beat accepted until next accepted start
pass  out  1  done && error_count==0
error_count  out  32  mismatching beats, saturates at 32'hFFFF_FFFF
first_error_addr  out  AW  byte address of first failing beat; 0 if none
M_AXI_ARADDR  out  AW  burst byte address
M_AXI_ARVALID  out  1  read request valid
M_AXI_ARLEN  out  8  constant 256/(DW/8)-1
M_AXI_ARSIZE  out  3  constant $clog2(DW/8)
M_AXI_ARBURST  out  2  constant 1 (INCR)
M_AXI_ARID/ARLOCK/ARCACHE/ARQOS/ARPROT  out  IW/1/4/4/3  constant 0
M_AXI_ARREADY  in  1  slave accepts request
M_AXI_RDATA  in  DW  read data
M_AXI_RID  in  IW  ignored
M_AXI_RRESP  in  2  nonzero is an error
M_AXI_RLAST  in  1  last beat of burst
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  equals busy

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, both state machines IDLE.
- Reset mid-run aborts the run; no done pulse. Outstanding R beats are the interconnect's concern (reset shared).
- Derived constants:
  - TOTAL_BURSTS = BRAM_SIZE/256
  - BEATS = 256/(DW/8)
  - LANES = DW/32
- AR FSM:
  - IDLE -> REQ on accepted start; ARADDR=0, ar_count=1.
  - In REQ, ARVALID=1 and ARADDR is stable until handshake.
  - On handshake: if ar_count==TOTAL_BURSTS -> IDLE; else ARADDR+=256, ar_count+=1.
  - No outstanding-request limit; RREADY is always high while busy.
- R FSM:
  - IDLE -> RUN on accepted start; clear error_count, first_error_addr, done; expected=0, beat=0, r_count=1.
  - On each RVALID&RREADY: lane i must equal expected+i (32-bit wrap). Then expected+=LANES, beat+=1.
  - A beat fails if any lane mismatches, or RRESP!=0, or RLAST != (beat==BEATS-1). Failure counts once per beat.
  - The first failing beat captures its address, r_beat_index*(DW/8), as 32-bit truncated to AW.
  - On final beat (beat==BEATS-1 and r_count==TOTAL_BURSTS): next cycle done=1, busy=0, RUN->IDLE. Otherwise at burst end: beat=0, r_count+=1.
- Failure on the final beat is counted before done asserts; pass reflects it in the same cycle done rises.
- start coinciding with done high: accepted; done clears next cycle.
- error_count and first_error_addr hold after done until the next accepted start.

Decomposition:
- Package fill_pkg holds constants shared with the fill engine:
  - BURST_SIZE=256
  - AXI_BURST_INCR=1
  - RESP_OKAY=0
  - functions for BEATS(DW) and LANES(DW)
- One combinational sub-module, pattern_cmp (DW, base -> mismatch), compares LANES words against base+i. It is reusable by the fill engine's self-test.

Test Plan:
- BRAM_SIZE=32'h400, ideal slave preloaded with word[n]=n, pulse start -> 4 AR bursts at 0x000/0x100/0x200/0x300 with ARLEN=3; done after 16th beat; pass=1, error_count=0.
- Same, word at byte 0x1C4 set to 0xDEAD_BEEF -> error_count=1, first_error_addr=0x1C0, pass=0.
- RRESP=2 on beat 9, data correct -> error_count=1, first_error_addr=0x240.
- Random ARREADY stalls and RVALID gaps (50%) -> ARADDR held during stall; result identical to scenario 1.
- start pulsed while busy -> ignored, single run, 4 AR handshakes total. Second start after done clears counters and reruns.
- resetn low mid-run (after 2 bursts) -> all outputs 0 asynchronously; fresh start completes with pass=1.
